// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core data-memory interface.
// Serves RV32I byte/half/word loads and stores with WAIT_CYCLES extra latency,
// flagging misaligned, illegal-funct3 and out-of-range accesses as errors.
// Optional DMEM_STATS_EN adds saturating load/store/error response counters.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] ld_count,
    output logic [15:0] st_count,
    output logic [15:0] err_count
`endif
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [WORDS];

    logic                  w_accept, w_hs, w_commit, w_req_err;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_word, w_ld, w_wd;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [3:0]            w_be;
    logic                  w_unused_addr;

    // req_ready also gated by reset so it reads 0 while reset is held
    assign req_ready = (r_state == S_IDLE) && reset;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE);

    assign w_accept = req_valid && req_ready;
    assign w_hs     = rsp_valid && rsp_ready;
    // counter is loaded with WAIT_CYCLES+1 so RESP entry lands WAIT_CYCLES+1 edges after accept
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 5'd1);

    assign w_idx         = r_addr[DEPTH_LOG2+1:2];
    assign w_word        = r_mem[w_idx];
    assign w_byte        = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half        = r_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_unused_addr = ^r_addr[31:DEPTH_LOG2+2];

    // classify the incoming request: alignment, funct3 legality and range
    always_comb begin
        w_req_err = 1'b0;
        if (req_write) begin
            case (req_funct3)
                3'b000:  w_req_err = 1'b0;
                3'b001:  w_req_err = req_addr[0];
                3'b010:  w_req_err = |req_addr[1:0];
                default: w_req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: w_req_err = 1'b0;
                3'b001, 3'b101: w_req_err = req_addr[0];
                3'b010:         w_req_err = |req_addr[1:0];
                default:        w_req_err = 1'b1;
            endcase
        end
        if ((req_addr >> 2) >= 32'(WORDS)) w_req_err = 1'b1;
    end

    // load extension and store byte-lane enables from the captured request
    always_comb begin
        w_ld = 32'h0;
        w_be = 4'b0000;
        w_wd = r_wdata;
        case (r_funct3)
            3'b000: begin
                w_ld = {{24{w_byte[7]}}, w_byte};
                w_be = 4'b0001 << r_addr[1:0];
                w_wd = {4{r_wdata[7:0]}};
            end
            3'b001: begin
                w_ld = {{16{w_half[15]}}, w_half};
                w_be = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{r_wdata[15:0]}};
            end
            3'b010: begin
                w_ld = w_word;
                w_be = 4'b1111;
            end
            3'b100:  w_ld = {24'h0, w_byte};
            3'b101:  w_ld = {16'h0, w_half};
            default: w_ld = 32'h0;
        endcase
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_WAIT;
            S_WAIT:  if (w_commit) w_next = S_RESP;
            S_RESP:  if (w_hs)     w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // state, request capture, wait counter and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_write   <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
                r_cnt    <= 5'(WAIT_CYCLES + 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 5'd1;
            end
            if (w_commit) begin
                r_rdata   <= (r_write || r_err) ? 32'h0 : w_ld;
                r_rsp_err <= r_err;
            end else if (w_hs) begin
                r_rdata   <= 32'h0;
                r_rsp_err <= 1'b0;
            end
        end
    end

    // data array: not reset; legal stores commit on RESP entry
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !r_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
            end
        end
    end

`ifdef DMEM_STATS_EN
    // saturating counters of completed responses by kind
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_count  <= 16'h0;
            st_count  <= 16'h0;
            err_count <= 16'h0;
        end else if (w_hs) begin
            if (r_rsp_err) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'h1;
            end else if (r_write) begin
                if (st_count != 16'hFFFF) st_count <= st_count + 16'h1;
            end else begin
                if (ld_count != 16'hFFFF) ld_count <= ld_count + 16'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES 1, 3 and 0.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic [2:0]  rdy, vld, er, bs;
    logic [31:0] rd [3];
    int          checks;
    int          fails;
`ifdef DMEM_STATS_EN
    logic [15:0] ldc [3];
    logic [15:0] stc [3];
    logic [15:0] erc [3];
`endif

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(rdy[0]),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bs[0])
`ifdef DMEM_STATS_EN
        , .ld_count(ldc[0]), .st_count(stc[0]), .err_count(erc[0])
`endif
    );

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(rdy[1]),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bs[1])
`ifdef DMEM_STATS_EN
        , .ld_count(ldc[1]), .st_count(stc[1]), .err_count(erc[1])
`endif
    );

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(rdy[2]),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bs[2])
`ifdef DMEM_STATS_EN
        , .ld_count(ldc[2]), .st_count(stc[2]), .err_count(erc[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request on instance d with rsp_ready held high; returns edges from accept to rsp_valid (-1 on timeout)
    task automatic xfer(input int d, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] data, output logic e);
        @(negedge clk);
        req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_write = ~wr; req_addr = 32'hFFFF_FFFF; req_wdata = ~wd;
        lat = -1; data = 32'hX; e = 1'bX;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (vld[d]) begin lat = i; break; end
        end
        if (lat > 0) begin
            data = rd[d]; e = er[d];
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rdy !== 3'b000) begin fails++; $display("FAIL rst_ready got=%b exp=000", rdy); end
        checks++; if (vld !== 3'b000 || er !== 3'b000 || bs !== 3'b000) begin fails++; $display("FAIL rst_flags vld=%b err=%b busy=%b exp=0", vld, er, bs); end
        checks++; if (rd[0] !== 32'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", rd[0]); end
        reset = 1'b1;
        #1;
        checks++; if (rdy !== 3'b111) begin fails++; $display("FAIL rst_release_ready got=%b exp=111", rdy); end
    endtask

    task automatic test_word;
        int lat; logic [31:0] d; logic e;
        xfer(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, lat, d, e);
        checks++; if (lat !== 2) begin fails++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL sw_rsp got=%h err=%b exp=0 err=0", d, e); end
        xfer(0, 0, 3'b010, 32'h10, 32'h0, lat, d, e);
        checks++; if (lat !== 2) begin fails++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL lw_data got=%h err=%b exp=deadbeef", d, e); end
    endtask

    task automatic test_byte;
        int lat; logic [31:0] d; logic e;
        xfer(0, 1, 3'b010, 32'h10, 32'h11223344, lat, d, e);
        xfer(0, 1, 3'b000, 32'h13, 32'h000000A5, lat, d, e);
        checks++; if (e !== 1'b0) begin fails++; $display("FAIL sb_err got=%b exp=0", e); end
        xfer(0, 0, 3'b010, 32'h10, 32'h0, lat, d, e);
        checks++; if (d !== 32'hA5223344) begin fails++; $display("FAIL sb_word got=%h exp=a5223344", d); end
        xfer(0, 0, 3'b000, 32'h13, 32'h0, lat, d, e);
        checks++; if (d !== 32'hFFFFFFA5) begin fails++; $display("FAIL lb got=%h exp=ffffffa5", d); end
        xfer(0, 0, 3'b100, 32'h13, 32'h0, lat, d, e);
        checks++; if (d !== 32'h000000A5) begin fails++; $display("FAIL lbu got=%h exp=000000a5", d); end
        xfer(0, 0, 3'b100, 32'h11, 32'h0, lat, d, e);
        checks++; if (d !== 32'h00000033) begin fails++; $display("FAIL lbu_lane1 got=%h exp=00000033", d); end
    endtask

    task automatic test_half;
        int lat; logic [31:0] d; logic e;
        xfer(0, 1, 3'b001, 32'h12, 32'hFFFF8001, lat, d, e);
        checks++; if (e !== 1'b0 || d !== 32'h0) begin fails++; $display("FAIL sh_rsp got=%h err=%b exp=0", d, e); end
        xfer(0, 0, 3'b001, 32'h12, 32'h0, lat, d, e);
        checks++; if (d !== 32'hFFFF8001) begin fails++; $display("FAIL lh got=%h exp=ffff8001", d); end
        xfer(0, 0, 3'b101, 32'h12, 32'h0, lat, d, e);
        checks++; if (d !== 32'h00008001) begin fails++; $display("FAIL lhu got=%h exp=00008001", d); end
        xfer(0, 0, 3'b010, 32'h10, 32'h0, lat, d, e);
        checks++; if (d !== 32'h80013344) begin fails++; $display("FAIL sh_word got=%h exp=80013344", d); end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] d; logic e;
        xfer(0, 1, 3'b010, 32'h20, 32'h01020304, lat, d, e);
        xfer(0, 1, 3'b010, 32'h00, 32'h55AA55AA, lat, d, e);
        xfer(0, 0, 3'b010, 32'h11, 32'h0, lat, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL err_lw_mis got=%h err=%b exp=0 err=1", d, e); end
        xfer(0, 1, 3'b001, 32'h21, 32'hFFFFFFFF, lat, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL err_sh_mis got=%h err=%b exp=0 err=1", d, e); end
        xfer(0, 0, 3'b010, 32'h20, 32'h0, lat, d, e);
        checks++; if (d !== 32'h01020304 || e !== 1'b0) begin fails++; $display("FAIL err_sh_nowrite got=%h exp=01020304", d); end
        xfer(0, 0, 3'b011, 32'h10, 32'h0, lat, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL err_f3_ld got=%h err=%b exp=0 err=1", d, e); end
        xfer(0, 1, 3'b011, 32'h20, 32'hFFFFFFFF, lat, d, e);
        checks++; if (e !== 1'b1) begin fails++; $display("FAIL err_f3_st got err=%b exp=1", e); end
        xfer(0, 0, 3'b001, 32'h13, 32'h0, lat, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL err_lh_mis got=%h err=%b exp=0 err=1", d, e); end
        xfer(0, 1, 3'b010, 32'h1000, 32'hFFFFFFFF, lat, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL err_range got=%h err=%b exp=0 err=1", d, e); end
        xfer(0, 0, 3'b010, 32'h00, 32'h0, lat, d, e);
        checks++; if (d !== 32'h55AA55AA) begin fails++; $display("FAIL err_range_nowrite got=%h exp=55aa55aa", d); end
        xfer(0, 0, 3'b010, 32'h20, 32'h0, lat, d, e);
        checks++; if (d !== 32'h01020304) begin fails++; $display("FAIL err_f3_nowrite got=%h exp=01020304", d); end
        xfer(0, 1, 3'b010, 32'hFFC, 32'h0BADF00D, lat, d, e);
        checks++; if (e !== 1'b0) begin fails++; $display("FAIL top_word_err got=%b exp=0", e); end
        xfer(0, 0, 3'b010, 32'hFFC, 32'h0, lat, d, e);
        checks++; if (d !== 32'h0BADF00D) begin fails++; $display("FAIL top_word got=%h exp=0badf00d", d); end
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] d; logic e; bit seen;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (vld[0]) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin fails++; $display("FAIL bp_timeout got=0 exp=rsp_valid"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid[0] = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
            checks++;
            if (vld[0] !== 1'b1 || rd[0] !== 32'h80013344 || er[0] !== 1'b0 || rdy[0] !== 1'b0) begin
                fails++; $display("FAIL bp_hold cyc=%0d vld=%b data=%h err=%b ready=%b exp=1 80013344 0 0", k, vld[0], rd[0], er[0], rdy[0]);
            end
        end
        @(negedge clk);
        req_valid[0] = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (vld[0] !== 1'b0 || rd[0] !== 32'h0 || bs[0] !== 1'b0) begin fails++; $display("FAIL bp_release vld=%b data=%h busy=%b exp=0", vld[0], rd[0], bs[0]); end
        xfer(0, 0, 3'b010, 32'h10, 32'h0, lat, d, e);
        checks++; if (d !== 32'h80013344) begin fails++; $display("FAIL bp_ignored_store got=%h exp=80013344", d); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] d; logic e;
        xfer(1, 1, 3'b010, 32'h20, 32'h12345678, lat, d, e);
        checks++; if (lat !== 4) begin fails++; $display("FAIL w3_latency got=%0d exp=4", lat); end
        @(negedge clk);
        req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (rdy[1] !== 1'b0 || vld[1] !== 1'b0 || bs[1] !== 1'b0 || er[1] !== 1'b0 || rd[1] !== 32'h0) begin
            fails++; $display("FAIL mid_reset ready=%b vld=%b busy=%b err=%b data=%h exp=all 0", rdy[1], vld[1], bs[1], er[1], rd[1]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        xfer(1, 0, 3'b010, 32'h20, 32'h0, lat, d, e);
        checks++; if (d !== 32'h12345678 || lat !== 4) begin fails++; $display("FAIL mid_reset_nowrite got=%h lat=%0d exp=12345678 lat=4", d, lat); end
    endtask

    task automatic test_zero_wait;
        int lat; logic [31:0] d; logic e;
        xfer(2, 1, 3'b010, 32'h40, 32'h0000000A, lat, d, e);
        checks++; if (lat !== 1) begin fails++; $display("FAIL w0_sw_latency got=%0d exp=1", lat); end
        xfer(2, 0, 3'b010, 32'h40, 32'h0, lat, d, e);
        checks++; if (lat !== 1 || d !== 32'h0000000A) begin fails++; $display("FAIL w0_lw got=%h lat=%0d exp=0000000a lat=1", d, lat); end
    endtask

    initial begin
        checks = 0; fails = 0;
        reset = 1'b0; req_valid = 3'b000; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_zero_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
